// File: rtl/inst_encoder.sv
// RISC-V instruction packer: decoded fields + immediate -> 32-bit word, with a
// representability check and a 2-entry output buffer behind valid/ready.
package inst_encoder_pkg;
    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } inst_format_e;
endpackage

module inst_encoder #(
    parameter int CNT_W = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  inst_encoder_pkg::inst_format_e    in_format,
    input  logic [6:0]                        in_opcode,
    input  logic [4:0]                        in_rd,
    input  logic [4:0]                        in_rs1,
    input  logic [4:0]                        in_rs2,
    input  logic [2:0]                        in_funct3,
    input  logic [6:0]                        in_funct7,
    input  logic [31:0]                       in_imm,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [31:0]                       out_inst,
    output logic                              out_err,
    output logic [CNT_W-1:0]                  enc_count,
    output logic [CNT_W-1:0]                  err_count
);
    import inst_encoder_pkg::*;

    logic signed [31:0] simm;
    logic [31:0]        enc;
    logic               err;

    assign simm = in_imm;

    always_comb begin
        enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        err = 1'b0;
        case (in_format)
            I_TYPE: begin
                enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                err = (simm < -2048) || (simm > 2047);
            end
            S_TYPE: begin
                enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                err = (simm < -2048) || (simm > 2047);
            end
            B_TYPE: begin
                enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], in_opcode};
                err = (simm < -4096) || (simm > 4094) || in_imm[0];
            end
            U_TYPE: begin
                enc = {in_imm[31:12], in_rd, in_opcode};
                err = (in_imm[11:0] != 12'd0);
            end
            J_TYPE: begin
                enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                err = (simm < -1048576) || (simm > 1048574) || in_imm[0];
            end
            default: ;
        endcase
    end

    // Each entry holds {err, inst}; rd_ptr is the head that drives the outputs.
    logic [1:0][32:0] buf_q;
    logic             rd_ptr, wr_ptr;
    logic [1:0]       count;
    logic             push, pop;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_inst  = out_valid ? buf_q[rd_ptr][31:0] : 32'd0;
    assign out_err   = out_valid ? buf_q[rd_ptr][32]   : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q     <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
            enc_count <= '0;
            err_count <= '0;
        end else begin
            if (push) begin
                buf_q[wr_ptr] <= {err, enc};
                wr_ptr        <= ~wr_ptr;
                enc_count     <= enc_count + CNT_W'(1);
                if (err)
                    err_count <= err_count + CNT_W'(1);
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: packing, range errors, backpressure, reset, round trip.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    inst_format_e in_format = R_TYPE;
    logic [6:0]   in_opcode = '0;
    logic [4:0]   in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]   in_funct3 = '0;
    logic [6:0]   in_funct7 = '0;
    logic [31:0]  in_imm = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  out_inst;
    logic         out_err;
    logic [15:0]  enc_count, err_count;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] popped[$];

    inst_encoder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_format(in_format),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_err(out_err), .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Inputs only move at posedge+1, so negedge values are what the next edge sees.
    always @(negedge clk)
        if (!rst && out_valid && out_ready)
            popped.push_back(out_inst);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] imm_gen(input inst_format_e f, input logic [31:0] i);
        case (f)
            I_TYPE:  return {{20{i[31]}}, i[31:20]};
            S_TYPE:  return {{20{i[31]}}, i[31:25], i[11:7]};
            B_TYPE:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            U_TYPE:  return {i[31:12], 12'd0};
            J_TYPE:  return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_req(input inst_format_e f, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm);
        in_format = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input inst_format_e f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        bit done = 0;
        set_req(f, op, rd, rs1, rs2, f3, f7, imm);
        for (int c = 0; c < 20 && !done; c++) begin
            done = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] imm;
        inst_format_e f;

        // Reset state
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_enc_count", 32'(enc_count), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic packing, one cycle after accept
        send(I_TYPE, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        chk("i_valid", 32'(out_valid), 32'd1);
        chk("i_inst", out_inst, 32'hFFF0_0093);
        chk("i_err", 32'(out_err), 32'd0);
        chk("i_enc_count", 32'(enc_count), 32'd1);
        send(S_TYPE, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        chk("s_inst", out_inst, 32'h0020_A423);
        chk("s_err", 32'(out_err), 32'd0);
        send(B_TYPE, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
        chk("b_inst", out_inst, 32'hFE00_0EE3);
        chk("b_err", 32'(out_err), 32'd0);
        send(U_TYPE, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        chk("u_inst", out_inst, 32'h1234_52B7);
        chk("u_err", 32'(out_err), 32'd0);
        chk("basic_enc_count", 32'(enc_count), 32'd4);
        chk("basic_err_count", 32'(err_count), 32'd0);

        // Range errors, truncated packing
        do_reset();
        send(B_TYPE, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        chk("b3_inst", out_inst, 32'h0000_0163);
        chk("b3_err", 32'(out_err), 32'd1);
        send(I_TYPE, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        chk("i2048_inst", out_inst, 32'h8000_0013);
        chk("i2048_err", 32'(out_err), 32'd1);
        send(U_TYPE, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
        chk("ulow_inst", out_inst, 32'h1234_5037);
        chk("ulow_err", 32'(out_err), 32'd1);
        chk("errs_enc_count", 32'(enc_count), 32'd3);
        chk("errs_err_count", 32'(err_count), 32'd3);
        // Boundary values that are still legal
        send(I_TYPE, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048);
        chk("i_min_err", 32'(out_err), 32'd0);
        send(J_TYPE, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048574);
        chk("j_max_err", 32'(out_err), 32'd0);
        chk("j_max_inst", out_inst, 32'h7FFF_F06F);
        send(J_TYPE, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576);
        chk("j_over_err", 32'(out_err), 32'd1);
        @(posedge clk); #1;

        // Backpressure: A, B fill the buffer, C waits
        do_reset();
        out_ready = 1'b0;
        popped.delete();
        send(R_TYPE, 7'h33, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);   // A = 0x000000B3
        send(R_TYPE, 7'h33, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);   // B = 0x00000133
        set_req(R_TYPE, 7'h33, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0); // C = 0x000001B3
        for (int c = 0; c < 3; c++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_inst", out_inst, 32'h0000_00B3);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        chk("bp_enc_count", 32'(enc_count), 32'd2);
        out_ready = 1'b1;
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("bp_after_pop_ready", 32'(in_ready), 32'd1);
        chk("bp_head_b", out_inst, 32'h0000_0133);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_head_c", out_inst, 32'h0000_01B3);
        @(posedge clk); #1;
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_pop_count", popped.size(), 32'd3);
        if (popped.size() == 3) begin
            chk("bp_order0", popped[0], 32'h0000_00B3);
            chk("bp_order1", popped[1], 32'h0000_0133);
            chk("bp_order2", popped[2], 32'h0000_01B3);
        end
        chk("bp_enc_final", 32'(enc_count), 32'd3);

        // Round trip through an independent immediate generator
        for (int k = 0; k < 20; k++) begin
            case (k % 5)
                0: begin f = I_TYPE; imm = 32'(int'($urandom_range(0, 4095)) - 2048); end
                1: begin f = S_TYPE; imm = 32'(int'($urandom_range(0, 4095)) - 2048); end
                2: begin f = B_TYPE; imm = 32'(int'($urandom_range(0, 4094)) * 2 - 4096); end
                3: begin f = U_TYPE; imm = {$urandom_range(0, 20'hFFFFF) & 32'hFFFFF, 12'd0} ; end
                default: begin f = J_TYPE; imm = 32'(int'($urandom_range(0, 1048574)) * 2 - 1048576); end
            endcase
            send(f, 7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 7'd0, imm);
            chk("rt_imm", imm_gen(f, out_inst), imm);
            chk("rt_err", 32'(out_err), 32'd0);
        end
        @(posedge clk); #1;

        // Reset with two words buffered
        out_ready = 1'b0;
        send(I_TYPE, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        send(I_TYPE, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
        chk("pre_rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_inst", out_inst, 32'd0);
        chk("mid_rst_enc", 32'(enc_count), 32'd0);
        chk("mid_rst_err", 32'(err_count), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        send(R_TYPE, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF);
        chk("r_inst", out_inst, 32'h4020_81B3);
        chk("r_err", 32'(out_err), 32'd0);
        chk("r_enc_count", 32'(enc_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
